// File: rtl/sparc_ram_ctrl.sv
// Byte-addressable RAM for the SPARC MPU datapath with an MFC completion handshake,
// programmable wait states, big-endian lane steering, signed loads and alignment errors.
module sparc_ram_ctrl #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  MOV,
  input  logic                  RW,
  input  logic [1:0]            Type,
  input  logic                  Signed,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC,
  output logic                  Beat,
  output logic                  Busy,
  output logic                  AlignErr
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD = 4'(WAIT_STATES - 1);

  // state | meaning
  // IDLE  | waiting for MOV; only state that samples the request
  // WAIT  | first-beat wait-state countdown
  // ACK   | first/only beat completes (MFC, write commit)
  // WAIT2 | second doubleword beat countdown
  // ACK2  | second doubleword beat completes (MFC with Beat=1)
  // ERR   | one-cycle misalignment report
  typedef enum logic [2:0] {IDLE, WAIT, ACK, WAIT2, ACK2, ERR} state_t;

  logic [7:0]    mem [DEPTH];
  state_t        state;
  logic [3:0]    cnt;
  logic [IW-1:0] cur_addr;
  logic          cur_rw;
  logic [1:0]    cur_type;
  logic          cur_signed;
  logic [IW-1:0] in_idx;
  logic [IW-1:0] nxt_addr;
  logic          wr_en;

  // High address bits beyond the storage size wrap.
  assign in_idx   = IW'(32'(Address) % DEPTH);
  assign nxt_addr = cur_addr + IW'(4);
  assign wr_en    = (state == ACK || state == ACK2) && !cur_rw;

  function automatic logic misaligned(input logic [1:0] t, input logic [2:0] a);
    case (t)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a[1:0];
      2'b11:   misaligned = |a[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load(input logic [IW-1:0] a, input logic [1:0] t,
                                       input logic s);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a];
    b1 = mem[a + IW'(1)];
    b2 = mem[a + IW'(2)];
    b3 = mem[a + IW'(3)];
    case (t)
      2'b00:   load = {{24{s & b0[7]}}, b0};
      2'b01:   load = {{16{s & b0[7]}}, b0, b1};
      default: load = {b0, b1, b2, b3};
    endcase
  endfunction

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      case (cur_type)
        2'b00: mem[cur_addr] <= DataIn[7:0];
        2'b01: begin
          mem[cur_addr]          <= DataIn[15:8];
          mem[cur_addr + IW'(1)] <= DataIn[7:0];
        end
        default: begin
          mem[cur_addr]          <= DataIn[31:24];
          mem[cur_addr + IW'(1)] <= DataIn[23:16];
          mem[cur_addr + IW'(2)] <= DataIn[15:8];
          mem[cur_addr + IW'(3)] <= DataIn[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_addr   <= '0;
      cur_rw     <= 1'b0;
      cur_type   <= 2'b00;
      cur_signed <= 1'b0;
      DataOut    <= '0;
      MFC        <= 1'b0;
      Beat       <= 1'b0;
      Busy       <= 1'b0;
      AlignErr   <= 1'b0;
    end else begin
      MFC      <= 1'b0;
      Beat     <= 1'b0;
      AlignErr <= 1'b0;
      case (state)
        IDLE: begin
          if (MOV) begin
            if (misaligned(Type, Address[2:0])) begin
              state    <= ERR;
              AlignErr <= 1'b1;
            end else begin
              cur_addr   <= in_idx;
              cur_rw     <= RW;
              cur_type   <= Type;
              cur_signed <= Signed;
              Busy       <= 1'b1;
              if (WAIT_STATES == 0) begin
                state <= ACK;
                MFC   <= 1'b1;
                if (RW) DataOut <= load(in_idx, Type, Signed);
              end else begin
                state <= WAIT;
                cnt   <= WLOAD;
              end
            end
          end
        end
        WAIT, WAIT2: begin
          if (cnt == 4'd0) begin
            state <= (state == WAIT) ? ACK : ACK2;
            MFC   <= 1'b1;
            Beat  <= (state == WAIT2);
            if (cur_rw) DataOut <= load(cur_addr, cur_type, cur_signed);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          if (cur_type == 2'b11) begin
            cur_addr <= nxt_addr;
            if (WAIT_STATES == 0) begin
              state <= ACK2;
              MFC   <= 1'b1;
              Beat  <= 1'b1;
              if (cur_rw) DataOut <= load(nxt_addr, cur_type, cur_signed);
            end else begin
              state <= WAIT2;
              cnt   <= WLOAD;
            end
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        ACK2: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_ram_ctrl.sv
// Directed bench for sparc_ram_ctrl: a byte-array model predicts every cycle's outputs,
// and literal expectations pin the model on the documented scenarios.
module tb_sparc_ram_ctrl;
  localparam int AW = 9;
  localparam int DP = 256;
  localparam int WS = 2;

  logic          Clk = 1'b0;
  logic          Clr = 1'b1;
  logic          MOV = 1'b0;
  logic          RW = 1'b0;
  logic [1:0]    Type = 2'b00;
  logic          Signed = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [31:0]   DataIn = '0;
  logic [31:0]   DataOut;
  logic          MFC, Beat, Busy, AlignErr;

  sparc_ram_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DP), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Clr(Clr), .MOV(MOV), .RW(RW), .Type(Type), .Signed(Signed),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .Beat(Beat),
    .Busy(Busy), .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  logic [7:0] mm [DP];
  logic e_busy = 1'b0, e_mfc = 1'b0, e_beat = 1'b0, e_err = 1'b0;
  logic [31:0] e_data = '0;
  int cyc = 0, acc_cyc = 0, mfc_lat = 0;
  bit seen_mfc = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] t);
    return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input int a, input logic [1:0] t, input logic s);
    logic [31:0] v = '0;
    int n = nbytes(t);
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[(a + i) % DP]);
    if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void m_store(input int a, input logic [1:0] t, input logic [31:0] d);
    int n = nbytes(t);
    for (int i = 0; i < n; i++) mm[(a + i) % DP] = d[8*(n-1-i) +: 8];
  endfunction

  always @(posedge Clk) cyc = cyc + 1;

  always @(negedge Clk) begin
    check("busy", 32'(Busy), 32'(e_busy));
    check("mfc", 32'(MFC), 32'(e_mfc));
    check("alignerr", 32'(AlignErr), 32'(e_err));
    check("dataout", DataOut, e_data);
    if (e_mfc) check("beat", 32'(Beat), 32'(e_beat));
    if (MFC && !seen_mfc) begin
      seen_mfc = 1'b1;
      mfc_lat  = cyc - acc_cyc + 1;
    end
  end

  // Issues one request in the current IDLE cycle and returns in the bubble cycle after it.
  task automatic do_op(input logic rw, input logic [1:0] t, input logic s,
                       input logic [AW-1:0] a, input logic [31:0] d0, input logic [31:0] d1);
    int base = int'(a) % DP;
    int nb = (t == 2'b11) ? 2 : 1;
    bit mis = (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00) ||
              (t == 2'b11 && a[2:0] != 3'b000);
    MOV = 1'b1; RW = rw; Type = t; Signed = s; Address = a; DataIn = 32'hBAD0_BAD0;
    seen_mfc = 1'b0;
    @(posedge Clk); #1;
    acc_cyc = cyc;
    if (mis) begin
      e_err = 1'b1; MOV = 1'b0;
      @(posedge Clk); #1;
      e_err = 1'b0;
      return;
    end
    for (int b = 0; b < nb; b++) begin
      e_busy = 1'b1;
      for (int k = 0; k < WS; k++) begin
        @(posedge Clk); #1;
      end
      e_mfc = 1'b1; e_beat = (b == 1);
      if (rw) e_data = m_load(base + 4 * b, t, s);
      else DataIn = (b == 1) ? d1 : d0;
      MOV = 1'b0;
      @(posedge Clk); #1;
      if (!rw) m_store(base + 4 * b, t, DataIn);
      e_mfc = 1'b0; e_beat = 1'b0; DataIn = 32'hBAD0_BAD0;
    end
    e_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dw_exp;
    for (int i = 0; i < DP; i++) mm[i] = 8'(i * 37 + 11);
    mm[0] = 8'hDE; mm[1] = 8'hAD; mm[2] = 8'hBE; mm[3] = 8'hEF;
    for (int i = 0; i < DP; i++) dut.mem[i] = mm[i];

    repeat (3) @(posedge Clk);
    #1;
    check("rst_dataout", DataOut, 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    Clr = 1'b0;

    do_op(1'b1, 2'b10, 1'b0, 9'h000, 32'h0, 32'h0);
    check("lit_word0", DataOut, 32'hDEAD_BEEF);
    check("mfc_latency", 32'(mfc_lat), 32'd3);

    do_op(1'b1, 2'b00, 1'b1, 9'h002, 32'h0, 32'h0);
    check("lit_byte_s", DataOut, 32'hFFFF_FFBE);
    do_op(1'b1, 2'b00, 1'b0, 9'h002, 32'h0, 32'h0);
    check("lit_byte_u", DataOut, 32'h0000_00BE);
    do_op(1'b1, 2'b01, 1'b1, 9'h002, 32'h0, 32'h0);
    check("lit_half_s", DataOut, 32'hFFFF_BEEF);

    do_op(1'b0, 2'b00, 1'b0, 9'h001, 32'hFFFF_FF5A, 32'h0);
    do_op(1'b1, 2'b10, 1'b0, 9'h000, 32'h0, 32'h0);
    check("lit_merge", DataOut, 32'hDE5A_BEEF);
    check("lit_mem0", 32'(dut.mem[0]), 32'hDE);
    check("lit_mem2", 32'(dut.mem[2]), 32'hBE);
    check("lit_mem3", 32'(dut.mem[3]), 32'hEF);

    do_op(1'b0, 2'b11, 1'b0, 9'h008, 32'h0123_4567, 32'h89AB_CDEF);
    dw_exp = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 8; i++)
      check("lit_dw_mem", 32'(dut.mem[8 + i]), 32'(dw_exp[63 - 8 * i -: 8]));
    do_op(1'b1, 2'b11, 1'b0, 9'h008, 32'h0, 32'h0);
    check("lit_dw_rd", DataOut, 32'h89AB_CDEF);

    do_op(1'b1, 2'b10, 1'b0, 9'h006, 32'h0, 32'h0);
    do_op(1'b1, 2'b01, 1'b0, 9'h003, 32'h0, 32'h0);
    do_op(1'b0, 2'b11, 1'b0, 9'h004, 32'h1111_1111, 32'h2222_2222);
    check("lit_err_hold", DataOut, 32'h89AB_CDEF);

    do_op(1'b0, 2'b10, 1'b0, 9'h1FC, 32'hCAFE_F00D, 32'h0);
    check("lit_wrap_mem", 32'(dut.mem[252]), 32'hCA);
    do_op(1'b1, 2'b10, 1'b0, 9'h0FC, 32'h0, 32'h0);
    check("lit_wrap_rd", DataOut, 32'hCAFE_F00D);

    MOV = 1'b1; RW = 1'b0; Type = 2'b10; Address = 9'h020; DataIn = 32'h1122_3344;
    @(posedge Clk); #1;
    e_busy = 1'b1;
    #2;
    Clr = 1'b1; MOV = 1'b0;
    e_busy = 1'b0; e_data = '0;
    #1;
    check("clr_busy", 32'(Busy), 32'h0);
    check("clr_dataout", DataOut, 32'h0);
    @(posedge Clk); #1;
    Clr = 1'b0;
    for (int i = 0; i < 4; i++) check("clr_mem", 32'(dut.mem[32 + i]), 32'(mm[32 + i]));
    do_op(1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 32'h0);

    do_op(1'b0, 2'b01, 1'b0, 9'h030, 32'hAAAA_7E81, 32'h0);
    do_op(1'b1, 2'b01, 1'b1, 9'h030, 32'h0, 32'h0);
    check("lit_half_pos", DataOut, 32'h0000_7E81);
    do_op(1'b1, 2'b00, 1'b1, 9'h031, 32'h0, 32'h0);
    check("lit_byte_neg", DataOut, 32'hFFFF_FF81);

    for (int i = 0; i < DP; i++) check("final_mem", 32'(dut.mem[i]), 32'(mm[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
